// File: rtl/reset_sequencer.sv
// Reset sequencer: debounced reset requests, PLL-lock supervision, programmable hold and
// staggered per-domain release with a sticky cause register. Optional watchdog: RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int unsigned              NUM_SOURCES      = 2,
  parameter logic [NUM_SOURCES-1:0]   SOURCE_EDGE_MASK = 2'b01,
  parameter int unsigned              DEBOUNCE_CYCLES  = 4,
  parameter int unsigned              HOLD_CYCLES      = 255,
  parameter int unsigned              NUM_DOMAINS      = 2,
  parameter int unsigned              STAGGER_CYCLES   = 16,
  parameter int unsigned              WDT_WIDTH        = 24
) (
  input  logic                     io_mainClk,
  input  logic                     io_asyncReset_n,
  input  logic                     io_pllLocked,
  input  logic [NUM_SOURCES-1:0]   io_resetReq,
  input  logic                     io_causeClear,
`ifdef RESET_SEQ_WATCHDOG_EN
  input  logic                     io_wdtEnable,
  input  logic                     io_wdtKick,
`endif
  output logic [NUM_DOMAINS-1:0]   io_resetOut,
  output logic [NUM_SOURCES+1:0]   io_resetCause,
  output logic                     io_busy
);

  localparam int unsigned DebW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned StagMax = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int unsigned StagW   = (StagMax > 0) ? $clog2(StagMax + 1) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(HOLD_CYCLES);
  localparam logic [StagW-1:0] StagLast = StagW'(StagMax);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || WDT_WIDTH < 1 ||
      NUM_SOURCES < 1 || NUM_DOMAINS < 1) begin : g_bad_param
    $error("reset_sequencer: count and width parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    StReset,
    StWaitLock,
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [StagW-1:0]       stag_q, stag_d;
  logic [NUM_DOMAINS-1:0] out_q, out_d;
  logic [NUM_SOURCES+1:0] cause_q, cause_d, set_bits;
  logic [NUM_SOURCES:0]   sync1_q, sync2_q;
  logic [NUM_SOURCES-1:0] req_s, src_event;
  logic                   lock_s, lock_lost, any_event, wdt_event;
  int unsigned            stag_int;

  // Top bit carries the PLL lock, the rest the reset requests.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {io_pllLocked, io_resetReq};
      sync2_q <= sync1_q;
    end
  end

  assign req_s  = sync2_q[NUM_SOURCES-1:0];
  assign lock_s = sync2_q[NUM_SOURCES];

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    logic [DebW-1:0] cnt_q, cnt_d;
    logic            deb_q, deb_d;

    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (req_s[i] != deb_q) begin
        if (cnt_q == DebLast) deb_d = req_s[i];
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    if (SOURCE_EDGE_MASK[i]) begin : g_edge
      logic deb_prev_q;
      always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) deb_prev_q <= 1'b0;
        else                  deb_prev_q <= deb_q;
      end
      // Fires on release of the (debounced) button.
      assign src_event[i] = deb_prev_q & ~deb_q;
    end else begin : g_level
      assign src_event[i] = deb_q;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = '0;
    if (state_q == StRun) begin
      if (io_wdtKick)                    wdt_d = '0;
      else if (io_wdtEnable && !(&wdt_q)) wdt_d = wdt_q + 1'b1;
      else                               wdt_d = wdt_q;
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) wdt_q <= '0;
    else                  wdt_q <= wdt_d;
  end

  assign wdt_event = (state_q == StRun) && (&wdt_q);
`else
  assign wdt_event = 1'b0;
`endif

  assign any_event = (|src_event) | wdt_event;
  assign lock_lost = ~lock_s && (state_q inside {StHold, StRelease, StRun});
  assign stag_int  = 32'(stag_q);

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    stag_d  = '0;
    out_d   = '1;
    unique case (state_q)
      StReset:    state_d = StWaitLock;
      StWaitLock: if (lock_s) state_d = StHold;
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (!any_event) begin
          if (hold_q == HoldLast) state_d = StRelease;
          else                    hold_d  = (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;
        end
      end
      StRelease: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (any_event) begin
          state_d = StHold;
        end else begin
          stag_d = (stag_q == StagLast) ? stag_q : stag_q + 1'b1;
          for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            out_d[k] = (stag_int < k * STAGGER_CYCLES);
          end
          if (stag_q >= StagLast) state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s)        state_d = StWaitLock;
        else if (any_event) state_d = StHold;
        else                out_d   = '0;
      end
      default: state_d = StReset;
    endcase
  end

  // A cause being set in the clearing cycle survives the clear.
  always_comb begin
    set_bits                   = '0;
    set_bits[NUM_SOURCES-1:0]  = src_event;
    set_bits[NUM_SOURCES]      = lock_lost;
    set_bits[NUM_SOURCES+1]    = wdt_event;
    cause_d = io_causeClear ? set_bits : (cause_q | set_bits);
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state_q <= StReset;
      hold_q  <= '0;
      stag_q  <= '0;
      out_q   <= '1;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      out_q   <= out_d;
      cause_q <= cause_d;
    end
  end

  assign io_resetOut   = out_q;
  assign io_resetCause = cause_q;
  assign io_busy       = (state_q != StRun);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (HOLD=8, STAGGER=4, DEBOUNCE=4, WDT_WIDTH=4).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll;
  logic [1:0] req;
  logic       cause_clr;
  logic [1:0] rout;
  logic [3:0] cause;
  logic       busy;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic       wdt_en;
  logic       wdt_kick;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SOURCES      (2),
    .SOURCE_EDGE_MASK (2'b01),
    .DEBOUNCE_CYCLES  (4),
    .HOLD_CYCLES      (8),
    .NUM_DOMAINS      (2),
    .STAGGER_CYCLES   (4),
    .WDT_WIDTH        (4)
  ) dut (
    .io_mainClk      (clk),
    .io_asyncReset_n (rst_n),
    .io_pllLocked    (pll),
    .io_resetReq     (req),
    .io_causeClear   (cause_clr),
`ifdef RESET_SEQ_WATCHDOG_EN
    .io_wdtEnable    (wdt_en),
    .io_wdtKick      (wdt_kick),
`endif
    .io_resetOut     (rout),
    .io_resetCause   (cause),
    .io_busy         (busy)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll = 1'b1; req = 2'b00; cause_clr = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    wdt_en = 1'b0; wdt_kick = 1'b0;
`endif
    step(3);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL reset_out: got %b want 11", rout); end
    checks++; if (cause !== 4'b0000) begin errors++; $display("FAIL reset_cause: got %b want 0000", cause); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
  endtask

  task automatic test_powerup();
    rst_n = 1'b1;
    step(11);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL pwr_edge11: got %b want 11", rout); end
    step(1);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL pwr_out0_fall: got %b want 10", rout); end
    step(3);
    checks++; if ({rout, busy} !== 3'b101) begin errors++; $display("FAIL pwr_edge15: got %b want 101", {rout, busy}); end
    step(1);
    checks++; if ({rout, busy} !== 3'b000) begin errors++; $display("FAIL pwr_out1_fall: got %b want 000", {rout, busy}); end
  endtask

  task automatic test_debounce();
    logic seen;
    seen = 1'b0;
    req[0] = 1'b1; step(3); req[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rout !== 2'b00 || cause !== 4'b0000) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_ignored: got reset=%b want 0", seen); end
    req[0] = 1'b1; step(6); req[0] = 1'b0;
    step(6);
    checks++; if (rout !== 2'b00) begin errors++; $display("FAIL pulse_f6: got %b want 00", rout); end
    step(1);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL pulse_f7: got %b want 11", rout); end
    checks++; if (cause !== 4'b0001) begin errors++; $display("FAIL pulse_cause: got %b want 0001", cause); end
    step(9);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL pulse_out0: got %b want 10", rout); end
    step(4);
    checks++; if ({rout, busy} !== 3'b000) begin errors++; $display("FAIL pulse_run: got %b want 000", {rout, busy}); end
  endtask

  task automatic test_level();
    logic seen;
    seen = 1'b0;
    cause_clr = 1'b1; step(1); cause_clr = 1'b0;
    checks++; if (cause !== 4'b0000) begin errors++; $display("FAIL clr_plain: got %b want 0000", cause); end
    req[1] = 1'b1;
    step(6);
    checks++; if (rout !== 2'b00) begin errors++; $display("FAIL level_r6: got %b want 00", rout); end
    step(1);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL level_r7: got %b want 11", rout); end
    for (int i = 0; i < 43; i++) begin
      step(1);
      if (rout !== 2'b11) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL level_held: got release=%b want 0", seen); end
    req[1] = 1'b0;
    step(14);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL level_f14: got %b want 11", rout); end
    step(1);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL level_f15: got %b want 10", rout); end
    step(4);
    checks++; if ({rout, busy} !== 3'b000) begin errors++; $display("FAIL level_run: got %b want 000", {rout, busy}); end
    checks++; if (cause !== 4'b0010) begin errors++; $display("FAIL level_cause: got %b want 0010", cause); end
  endtask

  task automatic test_lock_loss();
    req[0] = 1'b1; step(6); req[0] = 1'b0;
    step(7);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL ll_trigger: got %b want 11", rout); end
    cause_clr = 1'b1; step(1); cause_clr = 1'b0;
    checks++; if (cause !== 4'b0000) begin errors++; $display("FAIL ll_clr: got %b want 0000", cause); end
    step(8);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL ll_release: got %b want 10", rout); end
    pll = 1'b0;
    step(2);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL ll_sync_lat: got %b want 10", rout); end
    step(1);
    checks++; if ({rout, busy} !== 3'b111) begin errors++; $display("FAIL ll_assert: got %b want 111", {rout, busy}); end
    checks++; if (cause !== 4'b0100) begin errors++; $display("FAIL ll_cause: got %b want 0100", cause); end
    step(5);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL ll_waitlock: got %b want 11", rout); end
    pll = 1'b1;
    step(11);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL relock_e11: got %b want 11", rout); end
    step(1);
    checks++; if (rout !== 2'b10) begin errors++; $display("FAIL relock_e12: got %b want 10", rout); end
    step(3);
    checks++; if ({rout, busy} !== 3'b101) begin errors++; $display("FAIL relock_e15: got %b want 101", {rout, busy}); end
    step(1);
    checks++; if ({rout, busy} !== 3'b000) begin errors++; $display("FAIL relock_e16: got %b want 000", {rout, busy}); end
  endtask

  task automatic test_cause_clear();
    req[0] = 1'b1; step(6); req[0] = 1'b0;
    step(6);
    checks++; if (cause !== 4'b0100) begin errors++; $display("FAIL cc_before: got %b want 0100", cause); end
    cause_clr = 1'b1; step(1); cause_clr = 1'b0;
    checks++; if (cause !== 4'b0001) begin errors++; $display("FAIL cc_set_wins: got %b want 0001", cause); end
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL cc_out: got %b want 11", rout); end
    step(13);
    checks++; if (rout !== 2'b00) begin errors++; $display("FAIL cc_run: got %b want 00", rout); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rout, busy, cause} !== 7'b1110000) begin
      errors++; $display("FAIL async_rst: got %b want 1110000", {rout, busy, cause});
    end
    step(2);
    rst_n = 1'b1;
    step(16);
    checks++; if ({rout, busy} !== 3'b000) begin errors++; $display("FAIL async_rerun: got %b want 000", {rout, busy}); end
  endtask

`ifdef RESET_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    logic seen;
    seen = 1'b0;
    wdt_en = 1'b1;
    step(15);
    checks++; if (rout !== 2'b00) begin errors++; $display("FAIL wdt_e15: got %b want 00", rout); end
    step(1);
    checks++; if (rout !== 2'b11) begin errors++; $display("FAIL wdt_fire: got %b want 11", rout); end
    checks++; if (cause !== 4'b1000) begin errors++; $display("FAIL wdt_cause: got %b want 1000", cause); end
    step(13);
    checks++; if (rout !== 2'b00) begin errors++; $display("FAIL wdt_rerun: got %b want 00", rout); end
    for (int i = 0; i < 6; i++) begin
      step(9);
      if (rout !== 2'b00) seen = 1'b1;
      wdt_kick = 1'b1; step(1); wdt_kick = 1'b0;
      if (rout !== 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wdt_kicked: got reset=%b want 0", seen); end
    wdt_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_debounce();
    test_level();
    test_lock_loss();
    test_cause_clear();
    test_async_reset();
`ifdef RESET_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
